// File: rtl/pipelined_adder.sv
// pipelined_adder: STAGES-deep chunked ripple add/sub with skewed operands, deskewed result and NZCV flags
module pipelined_adder #(
  parameter int WIDTH = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);
  localparam int CW = WIDTH / STAGES;
  logic              adv;
  logic [STAGES-1:0] vld, cq, ci, vi;
  logic [WIDTH-1:0]  aq [STAGES];
  logic [WIDTH-1:0]  bq [STAGES];
  logic [WIDTH-1:0]  rq [STAGES];
  logic [WIDTH-1:0]  ai [STAGES];
  logic [WIDTH-1:0]  bi [STAGES];
  logic [WIDTH-1:0]  ri [STAGES];
  logic [WIDTH-1:0]  rn [STAGES];
  logic [CW:0]       ch [STAGES];
  logic [CW-1:0]     s  [STAGES];
  assign adv       = ~vld[STAGES-1] | out_ready;
  assign in_ready  = ~reset_n | adv;
  assign out_valid = vld[STAGES-1];
  assign result    = rq[STAGES-1];
  assign flag_c    = cq[STAGES-1];
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign ai[k] = a;
      assign bi[k] = sub ? ~b : b;
      assign ci[k] = sub | cin;
      assign vi[k] = in_valid;
      assign ri[k] = '0;
    end else begin : g_next
      // operands travel whole so chunk k reaches its adder k cycles late
      assign ai[k] = aq[k-1];
      assign bi[k] = bq[k-1];
      assign ci[k] = cq[k-1];
      assign vi[k] = vld[k-1];
      assign ri[k] = rq[k-1];
    end
    assign ch[k][0] = ci[k];
    for (genvar i = 0; i < CW; i++) begin : g_fa
      assign s[k][i]    = ai[k][k*CW+i] ^ bi[k][k*CW+i] ^ ch[k][i];
      assign ch[k][i+1] = (ai[k][k*CW+i] & bi[k][k*CW+i]) | (ch[k][i] & (ai[k][k*CW+i] ^ bi[k][k*CW+i]));
    end
    assign rn[k] = (ri[k] & ~(WIDTH'({CW{1'b1}}) << (k*CW))) | (WIDTH'(s[k]) << (k*CW));
  end
  always_ff @(posedge clk)
    if (!reset_n) begin
      vld    <= '0;
      cq     <= '0;
      flag_n <= 1'b0;
      flag_z <= 1'b0;
      flag_v <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        aq[k] <= '0;
        bq[k] <= '0;
        rq[k] <= '0;
      end
    end else if (adv) begin
      vld <= vi;
      for (int k = 0; k < STAGES; k++)
        if (vi[k]) begin
          aq[k] <= ai[k];
          bq[k] <= bi[k];
          rq[k] <= rn[k];
          cq[k] <= ch[k][CW];
        end
      if (vi[STAGES-1]) begin
        flag_n <= rn[STAGES-1][WIDTH-1];
        flag_z <= ~|rn[STAGES-1];
        flag_v <= ch[STAGES-1][CW] ^ ch[STAGES-1][CW-1];
      end
    end
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed table, random stream, stall, flush and exhaustive 8-bit checks
module tb_pipelined_adder;
  typedef struct {logic [63:0] r; logic [3:0] f;} exp_t;
  typedef struct {logic [63:0] a, b; logic sub, cin; logic [63:0] r; logic [3:0] f;} vec_t;
  logic clk = 1'b0, reset_n = 1'b0;
  logic in_valid, in_ready, sub, cin, out_valid, out_ready, flag_n, flag_z, flag_c, flag_v;
  logic [63:0] a, b, result;
  logic v8, sub8, cin8;
  logic [7:0] a8, b8, r88, r81;
  logic ir88, ov88, n88, z88, c88, v88, ir81, ov81, n81, z81, c81, v81;
  int nvec = 0, nerr = 0;
  exp_t q64[$], q88[$], q81[$];
  exp_t em, e8, e1;
  logic [63:0] last_r = '0;
  vec_t tbl[13];
  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(64), .STAGES(4)) u64 (.clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v));
  pipelined_adder #(.WIDTH(8), .STAGES(8)) u88 (.clk(clk), .reset_n(reset_n), .in_valid(v8), .in_ready(ir88),
    .a(a8), .b(b8), .sub(sub8), .cin(cin8), .out_valid(ov88), .out_ready(1'b1), .result(r88),
    .flag_n(n88), .flag_z(z88), .flag_c(c88), .flag_v(v88));
  pipelined_adder #(.WIDTH(8), .STAGES(1)) u81 (.clk(clk), .reset_n(reset_n), .in_valid(v8), .in_ready(ir81),
    .a(a8), .b(b8), .sub(sub8), .cin(cin8), .out_valid(ov81), .out_ready(1'b1), .result(r81),
    .flag_n(n81), .flag_z(z81), .flag_c(c81), .flag_v(v81));

  function automatic exp_t model(input logic [63:0] x, y, input logic s, c, input int w);
    logic [64:0] m, bb, t;
    exp_t e;
    m = (65'd1 << w) - 65'd1;
    bb = {1'b0, s ? ~y : y} & m;
    t = ({1'b0, x} & m) + bb + 65'(s | c);
    e.r = t[63:0] & m[63:0];
    e.f = {e.r[w-1], e.r == 64'd0, t[w], (x[w-1] == bb[w-1]) && (e.r[w-1] != x[w-1])};
    return e;
  endfunction

  function automatic void chk(input string nm, input logic [63:0] act, exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  always @(negedge clk)
    if (reset_n) begin
      if (out_valid && !out_ready) chk("stall_in_ready", 64'(in_ready), 64'd0);
      if (out_valid && out_ready) begin
        if (q64.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_result: got %h expected none", result);
        end else begin
          em = q64.pop_front();
          chk("result", result, em.r);
          chk("nzcv", 64'({flag_n, flag_z, flag_c, flag_v}), 64'(em.f));
          last_r = em.r;
        end
      end
    end

  always @(negedge clk)
    if (reset_n && ov88 && q88.size() != 0) begin
      e8 = q88.pop_front();
      chk("s8_result", 64'(r88), e8.r);
      chk("s8_nzcv", 64'({n88, z88, c88, v88}), 64'(e8.f));
    end

  always @(negedge clk)
    if (reset_n && ov81 && q81.size() != 0) begin
      e1 = q81.pop_front();
      chk("s1_result", 64'(r81), e1.r);
      chk("s1_nzcv", 64'({n81, z81, c81, v81}), 64'(e1.f));
    end

  task automatic send(input logic [63:0] x, y, input logic s, c, input exp_t e);
    int n = 0;
    logic acc;
    a = x; b = y; sub = s; cin = c; in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = in_ready;
      if (acc) q64.push_back(e);
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 100);
    if (!acc) chk("accept_timeout", 64'(acc), 64'd1);
  endtask

  task automatic drain();
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (q64.size() != 0 && n < 100);
    #1;
    chk("drain", 64'(q64.size()), 64'd0);
  endtask

  task automatic latency();
    int lat = 1;
    while (lat < 20) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      lat++;
    end
    chk("latency", 64'(lat), 64'd4);
  endtask

  task automatic rnd_send();
    logic [63:0] x, y;
    logic s, c;
    x = {$urandom, $urandom}; y = {$urandom, $urandom};
    s = 1'($urandom); c = 1'($urandom);
    send(x, y, s, c, model(x, y, s, c, 64));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] u;
    tbl[0]  = '{64'h1, 64'h1, 1'b0, 1'b0, 64'h2, 4'b0000};
    tbl[1]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 4'b0110};
    tbl[2]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 4'b1001};
    tbl[3]  = '{64'h5, 64'h7, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000};
    tbl[4]  = '{64'h7, 64'h5, 1'b1, 1'b0, 64'h2, 4'b0010};
    tbl[5]  = '{64'h5, 64'h5, 1'b1, 1'b0, 64'h0, 4'b0110};
    tbl[6]  = '{64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011};
    tbl[7]  = '{64'h0000_0000_FFFF_FFFF, 64'h0, 1'b0, 1'b1, 64'h1_0000_0000, 4'b0000};
    tbl[8]  = '{64'h3, 64'h1, 1'b1, 1'b0, 64'h2, 4'b0010};
    tbl[9]  = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 4'b0111};
    tbl[10] = '{64'hFFFF_0000_FFFF_0000, 64'h0001_0000_0001_0000, 1'b0, 1'b0, 64'h0000_0001_0000_0000, 4'b0010};
    tbl[11] = '{64'h0, 64'h0, 1'b1, 1'b0, 64'h0, 4'b0110};
    tbl[12] = '{64'h5, 64'h7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000};
    in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0; out_ready = 1'b1;
    v8 = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0; cin8 = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_result", result, 64'd0);
    chk("reset_flags", 64'({flag_n, flag_z, flag_c, flag_v}), 64'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    send(64'h1, 64'h1, 1'b0, 1'b0, '{64'h2, 4'b0000});
    in_valid = 1'b0;
    latency();
    drain();
    for (int i = 0; i < 13; i++) send(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].cin, '{tbl[i].r, tbl[i].f});
    in_valid = 1'b0;
    drain();
    chk("hold_valid", 64'(out_valid), 64'd0);
    chk("hold_result", result, last_r);
    fork
      begin
        for (int i = 0; i < 20; i++) rnd_send();
        in_valid = 1'b0;
      end
      begin
        int n = 0, run = 0;
        while (!out_valid && n < 40) begin
          @(negedge clk);
          n++;
        end
        for (int j = 0; j < 20; j++) begin
          if (out_valid) run++;
          @(negedge clk);
        end
        chk("stream_consecutive", 64'(run), 64'd20);
      end
    join
    drain();
    fork
      begin
        for (int i = 0; i < 12; i++) rnd_send();
        in_valid = 1'b0;
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("stall_blocks_input", 64'(in_ready), 64'd0);
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    for (int i = 0; i < 3; i++) rnd_send();
    reset_n = 1'b0;
    in_valid = 1'b0;
    q64.delete();
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    chk("flush_result", result, 64'd0);
    for (int j = 0; j < 8; j++) begin
      chk("flush_no_output", 64'(out_valid), 64'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, '{64'h0, 4'b0110});
    in_valid = 1'b0;
    latency();
    drain();
    for (int i = 0; i < 65536; i++) begin
      u = 16'(i);
      a8 = u[7:0]; b8 = u[15:8]; sub8 = u[8] ^ u[0]; cin8 = u[9] ^ u[1]; v8 = 1'b1;
      q88.push_back(model(64'(a8), 64'(b8), sub8, cin8, 8));
      q81.push_back(model(64'(a8), 64'(b8), sub8, cin8, 8));
      @(posedge clk); #1;
    end
    v8 = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("s8_drained", 64'(q88.size()), 64'd0);
    chk("s1_drained", 64'(q81.size()), 64'd0);
    chk("s8_in_ready", 64'({ir88, ir81}), 64'd3);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
